alu_inst_enc: RTL and testbench

Pipelined RV64I integer-instruction encoder: the inverse of the ALU-control decoder. Accepts a 5-bit instruction code (same numbering the decoder emits on `inst_name`) plus register indices and an immediate, and produces the 32-bit instruction word with a valid/ready handshake. Sits in the DPI stimulus path, feeding the fetch/decode side with legal encodings and flagging illegal requests.

---
 rtl/alu_pkg.sv | 67 ++++++
 rtl/alu_enc_field.sv | 54 +++++
 rtl/alu_inst_enc.sv | 148 ++++++++++++++
 tb/tb_alu_inst_enc.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the RV64I integer-instruction encoder.
// Code numbering matches the ALU-control decoder's inst_name output.
package alu_pkg;

  localparam logic [4:0] INST_ADD   = 5'd0;
  localparam logic [4:0] INST_ADDW  = 5'd1;
  localparam logic [4:0] INST_SUB   = 5'd2;
  localparam logic [4:0] INST_SUBW  = 5'd3;
  localparam logic [4:0] INST_SLL   = 5'd4;
  localparam logic [4:0] INST_SLLW  = 5'd5;
  localparam logic [4:0] INST_SLT   = 5'd6;
  localparam logic [4:0] INST_SLTU  = 5'd7;
  localparam logic [4:0] INST_XOR   = 5'd8;
  localparam logic [4:0] INST_SRL   = 5'd9;
  localparam logic [4:0] INST_SRLW  = 5'd10;
  localparam logic [4:0] INST_SRA   = 5'd11;
  localparam logic [4:0] INST_SRAW  = 5'd12;
  localparam logic [4:0] INST_OR    = 5'd13;
  localparam logic [4:0] INST_AND   = 5'd14;
  localparam logic [4:0] INST_ADDI  = 5'd15;
  localparam logic [4:0] INST_ADDIW = 5'd16;
  localparam logic [4:0] INST_SLTI  = 5'd17;
  localparam logic [4:0] INST_SLTIU = 5'd18;
  localparam logic [4:0] INST_XORI  = 5'd19;
  localparam logic [4:0] INST_ORI   = 5'd20;
  localparam logic [4:0] INST_ANDI  = 5'd21;
  localparam logic [4:0] INST_SLLI  = 5'd22;
  localparam logic [4:0] INST_SLLIW = 5'd23;
  localparam logic [4:0] INST_SRLI  = 5'd24;
  localparam logic [4:0] INST_SRLIW = 5'd25;
  localparam logic [4:0] INST_SRAI  = 5'd26;
  localparam logic [4:0] INST_SRAIW = 5'd27;
  localparam logic [4:0] INST_LUI   = 5'd28;
  localparam logic [4:0] INST_AUIPC = 5'd29;
  localparam logic [4:0] INST_FAIL  = 5'd31;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_RW    = 7'b0111011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_IW    = 7'b0011011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SH64,
    FMT_SH32,
    FMT_U,
    FMT_ILL
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } s1_t;

endpackage

// File: rtl/alu_enc_field.sv
// Combinational code -> {format, opcode, funct3, funct7} lookup.
// For 64-bit shifts the funct6 field is funct7[6:1].
module alu_enc_field
  import alu_pkg::*;
(
  input  logic [4:0] code,
  output fmt_e       fmt,
  output logic [6:0] opcode,
  output logic [2:0] funct3,
  output logic [6:0] funct7
);

  always_comb begin
    fmt    = FMT_ILL;
    opcode = '0;
    funct3 = '0;
    funct7 = F7_BASE;
    case (code)
      INST_ADD:   begin fmt = FMT_R; opcode = OPC_R;  funct3 = 3'b000; end
      INST_ADDW:  begin fmt = FMT_R; opcode = OPC_RW; funct3 = 3'b000; end
      INST_SUB:   begin fmt = FMT_R; opcode = OPC_R;  funct3 = 3'b000; funct7 = F7_ALT; end
      INST_SUBW:  begin fmt = FMT_R; opcode = OPC_RW; funct3 = 3'b000; funct7 = F7_ALT; end
      INST_SLL:   begin fmt = FMT_R; opcode = OPC_R;  funct3 = 3'b001; end
      INST_SLLW:  begin fmt = FMT_R; opcode = OPC_RW; funct3 = 3'b001; end
      INST_SLT:   begin fmt = FMT_R; opcode = OPC_R;  funct3 = 3'b010; end
      INST_SLTU:  begin fmt = FMT_R; opcode = OPC_R;  funct3 = 3'b011; end
      INST_XOR:   begin fmt = FMT_R; opcode = OPC_R;  funct3 = 3'b100; end
      INST_SRL:   begin fmt = FMT_R; opcode = OPC_R;  funct3 = 3'b101; end
      INST_SRLW:  begin fmt = FMT_R; opcode = OPC_RW; funct3 = 3'b101; end
      INST_SRA:   begin fmt = FMT_R; opcode = OPC_R;  funct3 = 3'b101; funct7 = F7_ALT; end
      INST_SRAW:  begin fmt = FMT_R; opcode = OPC_RW; funct3 = 3'b101; funct7 = F7_ALT; end
      INST_OR:    begin fmt = FMT_R; opcode = OPC_R;  funct3 = 3'b110; end
      INST_AND:   begin fmt = FMT_R; opcode = OPC_R;  funct3 = 3'b111; end
      INST_ADDI:  begin fmt = FMT_I; opcode = OPC_I;  funct3 = 3'b000; end
      INST_ADDIW: begin fmt = FMT_I; opcode = OPC_IW; funct3 = 3'b000; end
      INST_SLTI:  begin fmt = FMT_I; opcode = OPC_I;  funct3 = 3'b010; end
      INST_SLTIU: begin fmt = FMT_I; opcode = OPC_I;  funct3 = 3'b011; end
      INST_XORI:  begin fmt = FMT_I; opcode = OPC_I;  funct3 = 3'b100; end
      INST_ORI:   begin fmt = FMT_I; opcode = OPC_I;  funct3 = 3'b110; end
      INST_ANDI:  begin fmt = FMT_I; opcode = OPC_I;  funct3 = 3'b111; end
      INST_SLLI:  begin fmt = FMT_SH64; opcode = OPC_I;  funct3 = 3'b001; end
      INST_SLLIW: begin fmt = FMT_SH32; opcode = OPC_IW; funct3 = 3'b001; end
      INST_SRLI:  begin fmt = FMT_SH64; opcode = OPC_I;  funct3 = 3'b101; end
      INST_SRLIW: begin fmt = FMT_SH32; opcode = OPC_IW; funct3 = 3'b101; end
      INST_SRAI:  begin fmt = FMT_SH64; opcode = OPC_I;  funct3 = 3'b101; funct7 = F7_ALT; end
      INST_SRAIW: begin fmt = FMT_SH32; opcode = OPC_IW; funct3 = 3'b101; funct7 = F7_ALT; end
      INST_LUI:   begin fmt = FMT_U; opcode = OPC_LUI; end
      INST_AUIPC: begin fmt = FMT_U; opcode = OPC_AUIPC; end
      INST_FAIL:  fmt = FMT_ILL;
      default:    fmt = FMT_ILL;
    endcase
  end

endmodule

// File: rtl/alu_inst_enc.sv
// Two-stage RV64I instruction encoder with valid/ready handshake:
// S1 holds the request and field decode, S2 the assembled word and error flag.
module alu_inst_enc
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_code,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  fmt_e       f_fmt;
  logic [6:0] f_opcode;
  logic [2:0] f_funct3;
  logic [6:0] f_funct7;

  alu_enc_field u_field (
    .code   (in_code),
    .fmt    (f_fmt),
    .opcode (f_opcode),
    .funct3 (f_funct3),
    .funct7 (f_funct7)
  );

  logic        s1_valid_q, s1_valid_d;
  s1_t         s1_q, s1_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_inst_q, s2_inst_d;
  logic        s2_err_q, s2_err_d;
  logic [15:0] enc_count_q, enc_count_d;
  logic [15:0] err_count_q, err_count_d;

  logic        s2_free, accept, advance, xfer;
  logic        asm_err;
  logic [31:0] asm_inst;

  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !flush && (!s1_valid_q || s2_free);
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid_q && s2_free;
  assign xfer     = s2_valid_q && out_ready;

  // Range checks and word assembly from the registered S1 fields.
  always_comb begin
    asm_err  = 1'b0;
    asm_inst = '0;
    case (s1_q.fmt)
      FMT_R: asm_inst = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      FMT_I: begin
        asm_err  = !((s1_q.imm[31:11] == '0) || (s1_q.imm[31:11] == '1));
        asm_inst = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      end
      FMT_SH64: begin
        asm_err  = |s1_q.imm[31:6];
        asm_inst = {s1_q.funct7[6:1], s1_q.imm[5:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      end
      FMT_SH32: begin
        asm_err  = |s1_q.imm[31:5];
        asm_inst = {s1_q.funct7, s1_q.imm[4:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      end
      FMT_U: begin
        asm_err  = |s1_q.imm[31:20];
        asm_inst = {s1_q.imm[19:0], s1_q.rd, s1_q.opcode};
      end
      default: asm_err = 1'b1;
    endcase
    if (asm_err) asm_inst = '0;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    s2_valid_d  = s2_valid_q;
    s2_inst_d   = s2_inst_q;
    s2_err_d    = s2_err_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;

    if (accept) begin
      s1_d.fmt    = f_fmt;
      s1_d.opcode = f_opcode;
      s1_d.funct3 = f_funct3;
      s1_d.funct7 = f_funct7;
      s1_d.rd     = in_rd;
      s1_d.rs1    = in_rs1;
      s1_d.rs2    = in_rs2;
      s1_d.imm    = in_imm;
    end
    if (advance) begin
      s2_inst_d = asm_inst;
      s2_err_d  = asm_err;
    end

    if (s2_free) s2_valid_d = s1_valid_q;
    if (accept)       s1_valid_d = 1'b1;
    else if (advance) s1_valid_d = 1'b0;

    // Flush drops in-flight work but an output transfer this cycle still counts.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end

    if (xfer) begin
      if (s2_err_q) err_count_d = err_count_q + 16'd1;
      else          enc_count_d = enc_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_inst_q   <= '0;
      s2_err_q    <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s2_valid_q  <= s2_valid_d;
      s2_inst_q   <= s2_inst_d;
      s2_err_q    <= s2_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = s2_inst_q;
  assign out_err   = s2_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_inst_enc.sv
// Randomized self-checking bench for alu_inst_enc against a scoreboard
// fed by an arithmetic reference encoder.
module tb_alu_inst_enc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_code, in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count, err_count;

  alu_inst_enc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int unsigned t;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] m_enc = '0;
  logic [15:0] m_err = '0;
  logic [31:0] last_inst = '0;
  logic        last_err = 1'b0;
  logic        last_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference encoder: field values straight from the RV64I tables, assembled arithmetically.
  function automatic exp_t ref_enc(input logic [4:0] code, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [31:0] imm);
    exp_t        e;
    int          kind;
    int unsigned op, f3, alt;
    longint      sv;
    longint      uv;
    e.inst = 0; e.err = 1'b0; e.t = 0;
    kind = 5; op = 0; f3 = 0; alt = 0;
    sv = longint'($signed(imm));
    uv = longint'(imm);
    case (code)
      5'd0:  begin kind = 0; op = 'h33; f3 = 0; end
      5'd1:  begin kind = 0; op = 'h3B; f3 = 0; end
      5'd2:  begin kind = 0; op = 'h33; f3 = 0; alt = 1; end
      5'd3:  begin kind = 0; op = 'h3B; f3 = 0; alt = 1; end
      5'd4:  begin kind = 0; op = 'h33; f3 = 1; end
      5'd5:  begin kind = 0; op = 'h3B; f3 = 1; end
      5'd6:  begin kind = 0; op = 'h33; f3 = 2; end
      5'd7:  begin kind = 0; op = 'h33; f3 = 3; end
      5'd8:  begin kind = 0; op = 'h33; f3 = 4; end
      5'd9:  begin kind = 0; op = 'h33; f3 = 5; end
      5'd10: begin kind = 0; op = 'h3B; f3 = 5; end
      5'd11: begin kind = 0; op = 'h33; f3 = 5; alt = 1; end
      5'd12: begin kind = 0; op = 'h3B; f3 = 5; alt = 1; end
      5'd13: begin kind = 0; op = 'h33; f3 = 6; end
      5'd14: begin kind = 0; op = 'h33; f3 = 7; end
      5'd15: begin kind = 1; op = 'h13; f3 = 0; end
      5'd16: begin kind = 1; op = 'h1B; f3 = 0; end
      5'd17: begin kind = 1; op = 'h13; f3 = 2; end
      5'd18: begin kind = 1; op = 'h13; f3 = 3; end
      5'd19: begin kind = 1; op = 'h13; f3 = 4; end
      5'd20: begin kind = 1; op = 'h13; f3 = 6; end
      5'd21: begin kind = 1; op = 'h13; f3 = 7; end
      5'd22: begin kind = 2; op = 'h13; f3 = 1; end
      5'd23: begin kind = 3; op = 'h1B; f3 = 1; end
      5'd24: begin kind = 2; op = 'h13; f3 = 5; end
      5'd25: begin kind = 3; op = 'h1B; f3 = 5; end
      5'd26: begin kind = 2; op = 'h13; f3 = 5; alt = 1; end
      5'd27: begin kind = 3; op = 'h1B; f3 = 5; alt = 1; end
      5'd28: begin kind = 4; op = 'h37; end
      5'd29: begin kind = 4; op = 'h17; end
      default: kind = 5;
    endcase
    case (kind)
      0: e.inst = 32'(alt * 32) * 32'h0200_0000 + 32'(rs2) * 32'h10_0000 + 32'(rs1) * 32'h8000
                + 32'(f3) * 32'h1000 + 32'(rd) * 32'h80 + 32'(op);
      1: begin
        e.err  = (sv < -2048) || (sv > 2047);
        e.inst = 32'(sv & 'hFFF) * 32'h10_0000 + 32'(rs1) * 32'h8000 + 32'(f3) * 32'h1000
               + 32'(rd) * 32'h80 + 32'(op);
      end
      2: begin
        e.err  = uv > 63;
        e.inst = 32'(alt * 16) * 32'h0400_0000 + 32'(uv % 64) * 32'h10_0000 + 32'(rs1) * 32'h8000
               + 32'(f3) * 32'h1000 + 32'(rd) * 32'h80 + 32'(op);
      end
      3: begin
        e.err  = uv > 31;
        e.inst = 32'(alt * 32) * 32'h0200_0000 + 32'(uv % 32) * 32'h10_0000 + 32'(rs1) * 32'h8000
               + 32'(f3) * 32'h1000 + 32'(rd) * 32'h80 + 32'(op);
      end
      4: begin
        e.err  = uv >= 64'd1048576;
        e.inst = 32'(uv % 1048576) * 32'h1000 + 32'(rd) * 32'h80 + 32'(op);
      end
      default: e.err = 1'b1;
    endcase
    if (e.err) e.inst = 0;
    return e;
  endfunction

  // One clock cycle: check at the falling edge, then advance past the rising edge.
  task automatic step();
    exp_t e;
    logic exp_rdy, exp_ov;
    last_acc = 1'b0;
    @(negedge clk);
    check("enc_count", 32'(enc_count), 32'(m_enc));
    check("err_count", 32'(err_count), 32'(m_err));
    exp_rdy = !flush && ((q.size() < 2) || out_ready);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    exp_ov = (q.size() > 0) && (cyc >= q[0].t + 1);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (out_valid && out_ready && q.size() > 0) begin
      check("out_inst", out_inst, q[0].inst);
      check("out_err", 32'(out_err), 32'(q[0].err));
      last_inst = out_inst;
      last_err  = out_err;
      if (q[0].err) m_err = m_err + 16'd1;
      else          m_enc = m_enc + 16'd1;
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (in_valid && in_ready) begin
      e = ref_enc(in_code, in_rd, in_rs1, in_rs2, in_imm);
      e.t = cyc + 1;
      q.push_back(e);
      last_acc = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [4:0] c, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [31:0] im);
    int unsigned n = 0;
    in_code = c; in_rd = rd; in_rs1 = r1; in_rs2 = r2; in_imm = im;
    in_valid = 1'b1;
    step();
    n++;
    while (!last_acc && n < 10) begin
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int unsigned n = 0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 20) begin
      step();
      n++;
    end
    if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [4:0] c, input logic [4:0] rd,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] im,
                          input logic [31:0] exp_inst, input logic exp_err);
    send(c, rd, r1, r2, im);
    drain();
    check({tag, "_inst"}, last_inst, exp_inst);
    check({tag, "_err"}, 32'(last_err), 32'(exp_err));
  endtask

  function automatic logic [31:0] pick_imm();
    case ($urandom_range(0, 9))
      0:       return $urandom();
      1, 2:    return 32'($urandom_range(0, 70));
      3:       return -32'($urandom_range(0, 2100));
      4:       return 32'($urandom_range(2040, 2055));
      5:       return 32'($urandom_range(0, 32'h10_0005));
      6:       return 32'($urandom_range(28, 66));
      7:       return 32'hFFFF_F7FF;
      8:       return 32'hFFFF_F800;
      default: return 32'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    int unsigned idx;
    int unsigned n;
    logic [15:0] base_enc, base_err;
    logic [4:0]  bp_code[3];
    logic [31:0] bp_imm[3];

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_code = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("add",    5'd0,  5'd3,  5'd1, 5'd2, 32'd0,        32'h0020_81B3, 1'b0);
    directed("sub",    5'd2,  5'd3,  5'd1, 5'd2, 32'd0,        32'h4020_81B3, 1'b0);
    directed("addi_m1", 5'd15, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    directed("addi_2048", 5'd15, 5'd1, 5'd0, 5'd0, 32'd2048,   32'h0000_0000, 1'b1);
    check("err_count_after_addi", 32'(err_count), 32'd1);
    directed("srai",   5'd26, 5'd5,  5'd6, 5'd0, 32'd63,       32'h43F3_5293, 1'b0);
    directed("sraiw32", 5'd27, 5'd5, 5'd6, 5'd0, 32'd32,       32'h0000_0000, 1'b1);
    directed("lui",    5'd28, 5'd10, 5'd0, 5'd0, 32'h0001_2345, 32'h1234_5537, 1'b0);
    directed("code30", 5'd30, 5'd1,  5'd1, 5'd1, 32'd0,        32'h0000_0000, 1'b1);
    directed("code31", 5'd31, 5'd1,  5'd1, 5'd1, 32'd0,        32'h0000_0000, 1'b1);
    check("directed_enc_count", 32'(enc_count), 32'd5);
    check("directed_err_count", 32'(err_count), 32'd4);

    // Backpressure: three requests offered while the consumer stalls for 5 cycles.
    bp_code = '{5'd0, 5'd8, 5'd20};
    bp_imm  = '{32'd0, 32'd0, 32'd100};
    base_enc = m_enc;
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      in_code = bp_code[idx]; in_rd = 5'(idx + 1); in_rs1 = 5'd4; in_rs2 = 5'd7;
      in_imm = bp_imm[idx]; in_valid = 1'b1;
      step();
      if (last_acc) idx++;
    end
    check("bp_accepted", idx, 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    n = 0;
    while (idx < 3 && n < 10) begin
      in_code = bp_code[idx]; in_rd = 5'(idx + 1); in_rs1 = 5'd4; in_rs2 = 5'd7;
      in_imm = bp_imm[idx]; in_valid = 1'b1;
      step();
      if (last_acc) idx++;
      n++;
    end
    in_valid = 1'b0;
    drain();
    check("bp_enc_delta", 32'(m_enc - base_enc), 32'd3);
    check("bp_enc_count", 32'(enc_count), 32'(base_enc + 16'd3));

    // Flush with both stages full and a fresh request pending.
    out_ready = 1'b0;
    send(5'd1, 5'd2, 5'd3, 5'd4, 32'd0);
    send(5'd29, 5'd9, 5'd0, 5'd0, 32'h000F_FFFF);
    base_enc = m_enc;
    base_err = m_err;
    flush = 1'b1;
    in_code = 5'd14; in_valid = 1'b1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    check("flush_no_accept", 32'(last_acc), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_enc_count", 32'(enc_count), 32'(base_enc));
    check("flush_err_count", 32'(err_count), 32'(base_err));
    out_ready = 1'b1;
    step();
    check("flush_stays_empty", 32'(out_valid), 32'd0);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_code   = 5'($urandom_range(0, 31));
      in_rd     = 5'($urandom());
      in_rs1    = 5'($urandom());
      in_rs2    = 5'($urandom());
      in_imm    = pick_imm();
      step();
    end
    flush = 1'b0; in_valid = 1'b0;
    drain();

    // Run legal traffic at full rate until enc_count wraps.
    in_code = 5'd0; in_rd = 5'd1; in_rs1 = 5'd2; in_rs2 = 5'd3; in_imm = '0;
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (m_enc != 16'hFFFF && n < 70000) begin
      step();
      n++;
    end
    check("wrap_at_ffff", 32'(enc_count), 32'h0000_FFFF);
    step();
    check("wrap_to_zero", 32'(enc_count), 32'd0);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset while work is in flight.
    out_ready = 1'b0;
    send(5'd4, 5'd1, 5'd2, 5'd3, 32'd0);
    send(5'd5, 5'd1, 5'd2, 5'd3, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_inst", out_inst, 32'd0);
    check("arst_enc_count", 32'(enc_count), 32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    q.delete();
    m_enc = '0;
    m_err = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    directed("post_rst_and", 5'd14, 5'd7, 5'd8, 5'd9, 32'd0, 32'h0094_73B3, 1'b0);
    check("post_rst_enc_count", 32'(enc_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
